imem_fetch_port: RTL and testbench
==================================

// Module: imem_fetch_port
// PURPOSE
//   Parametrised instruction memory with a valid/ready fetch port and byte-granular
//   (unaligned) fetch. A fetch that crosses a word boundary is assembled from two
//   single-port synchronous reads.
//   Sits between the IF-stage PC and the decode latch. Also has a word-load port for
//   program preload and self-test.
// PARAMETERS
//   WORD_W     32   fetch/storage word width, bits; multiple of 8 (BYTES = WORD_W/8)
//   DEPTH      256  number of stored words
//   ADDR_W     32   byte-address width on the fetch port
//   UNALIGNED  1    1: unaligned fetch allowed; 0: unaligned fetch returns error
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        reset, synchronous, active-high
//   req_valid  in   1        fetch request valid
//   req_ready  out  1        fetch request accepted when valid&ready
//   req_addr   in   ADDR_W   byte address of fetch
//   rsp_valid  out  1        response valid; held until rsp_ready
//   rsp_ready  in   1        consumer accepts response
//   rsp_data   out  WORD_W   fetched word, big-endian byte order (lowest address = MSB)
//   rsp_err    out  1        out-of-range or disallowed-unaligned fetch
//   ld_en      in   1        write ld_data into word ld_idx
//   ld_idx     in   clog2(DEPTH)  word index for load
//   ld_data    in   WORD_W   load data
// BEHAVIOUR
//   Reset: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0 during rst.
//     Memory contents are NOT cleared; they are written only through ld_en.
//   Definitions: widx = req_addr/BYTES; off = req_addr%BYTES; sh = 8*off.
//   FSM states:
//     IDLE: req_ready = !ld_en. On accept, read word widx.
//       - widx>=DEPTH, or (off!=0 && !UNALIGNED) -> RESP with err=1, data=0.
//       - off==0 -> RESP.
//       - otherwise -> HI.
//     HI: capture lo word; read widx+1.
//       - widx+1>=DEPTH -> err=1, data=0.
//       - else data = (lo<<sh) | (hi>>(WORD_W-sh)).
//       - -> RESP.
//     RESP: rsp_valid=1, data/err stable.
//       - rsp_ready=1: req_ready=!ld_en; a same-cycle accept is processed exactly as
//         in IDLE (back-to-back); no accept -> IDLE.
//       - rsp_ready=0: hold, req_ready=0.
//   Latency (accept in cycle N):
//     - aligned or error: rsp_valid at N+1.
//     - unaligned: rsp_valid at N+2.
//     - aligned throughput 1/cycle with rsp_ready held high.
//   Load port:
//     - ld_en has priority over the array port; forces req_ready=0 that cycle.
//     - In HI, ld_en stalls the second read one cycle (state held).
//     - Write takes effect at the clock edge; a fetch issued the next cycle sees the new
//       data.
//     - ld_en with ld_idx>=DEPTH is ignored.
//   Address wrap: no wrap past DEPTH-1; crossing into DEPTH is an error, never index 0.
//   Reset mid-operation: any in-flight fetch or pending response is discarded; FSM goes
//     to IDLE the next cycle.
//   No req_addr sampling outside accept; req_addr may change freely while req_ready=0.
// TESTING
//   1. Preload w0=0x11223344, w1=0x55667788; fetch 0x0 -> rsp at N+1: data 0x11223344,
//      err 0.
//   2. Fetch 0x1 -> rsp at N+2: data 0x22334455. Fetch 0x3 -> data 0x44556677.
//   3. Aligned fetches 0x0,0x4 back-to-back with rsp_ready=1 -> valid on consecutive
//      cycles, 0x11223344 then 0x55667788.
//   4. DEPTH=256: fetch 0x3FD -> err=1, data 0. Fetch 0x400 -> err=1, latency 1.
//      UNALIGNED=0: fetch 0x2 -> err=1.
//   5. rsp_ready low 3 cycles -> rsp_valid/data stable, req_ready=0. ld_en during an
//      unaligned fetch's HI -> response 1 cycle later with correct data.
//   6. rst asserted while in HI -> next cycle rsp_valid=0, state IDLE. Memory
//      preserved: refetch 0x0 = 0x11223344.

Source files
------------

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port and byte-granular fetch.
// An aligned fetch reads one word. A fetch that crosses a word boundary reads
// the low word, then the high word, and merges them in big-endian byte order.
// The word-load port shares the single array port and takes priority over it.
// WORD_W must be a multiple of 8 and at least 16.
module imem_fetch_port #(
   parameter int WORD_W    = 32,
   parameter int DEPTH     = 256,
   parameter int ADDR_W    = 32,
   parameter int UNALIGNED = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_W-1:0]        req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WORD_W-1:0]        rsp_data,
   output logic                     rsp_err,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_idx,
   input  logic [WORD_W-1:0]        ld_data
);

   localparam int BYTES = WORD_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HI,
      S_RESP
   } state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic [WORD_W-1:0]   lo_q, lo_d;
   logic [IDX_W-1:0]    widx_q, widx_d;
   logic [OFF_W-1:0]    off_q, off_d;

   logic [WORD_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   req_widx;
   logic [OFF_W-1:0]    req_off;
   logic                req_oob;
   logic [IDX_W:0]      nxt_idx;
   logic                hi_oob;
   logic [IDX_W-1:0]    rd_idx;
   logic [WORD_W-1:0]   rd_word;
   logic [WORD_W-1:0]   merged;
   logic                ld_hit;

   // Address decode: word index, byte offset and range checks.
   assign req_widx = req_addr >> OFF_W;
   assign req_off  = req_addr[OFF_W-1:0];
   assign req_oob  = req_widx >= ADDR_W'(DEPTH);
   assign nxt_idx  = {1'b0, widx_q} + 1'b1;
   assign hi_oob   = nxt_idx >= (IDX_W+1)'(DEPTH);
   assign ld_hit   = ld_en && ({1'b0, ld_idx} < (IDX_W+1)'(DEPTH));

   // The single array port reads the high word while in HI, else the request word.
   assign rd_idx  = (state_q == S_HI) ? nxt_idx[IDX_W-1:0] : req_widx[IDX_W-1:0];
   assign rd_word = mem[rd_idx];

   // Lowest address is the MSB: shift the low word up, bring the high word's top bytes down.
   assign merged = (lo_q << (8 * int'(off_q))) | (rd_word >> (WORD_W - 8 * int'(off_q)));

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   // Word-load write port; contents survive reset.
   // NOTE: the array has no reset branch so it maps onto RAM macros; contents are defined only by loads.
   always_ff @(posedge clk) begin
      if (ld_hit) begin
         mem[ld_idx] <= ld_data;
      end
   end

   // State and response registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         lo_q       <= '0;
         widx_q     <= '0;
         off_q      <= '0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         lo_q       <= lo_d;
         widx_q     <= widx_d;
         off_q      <= off_d;
      end
   end

   // Next-state, handshake and response assembly.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      lo_d       = lo_q;
      widx_d     = widx_q;
      off_d      = off_q;
      req_ready  = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = !ld_en;
         end
         S_HI: begin
            // A load owns the array port this cycle, so the high-word read waits.
            if (!ld_en) begin
               state_d = S_RESP;
               if (hi_oob) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
               end else begin
                  rsp_err_d  = 1'b0;
                  rsp_data_d = merged;
               end
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               req_ready = !ld_en;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rst) begin
         req_ready = 1'b0;
      end

      // Accept from IDLE or back-to-back from a consumed RESP is handled identically.
      if (req_valid && req_ready) begin
         if (req_oob || (req_off != '0 && UNALIGNED == 0)) begin
            state_d    = S_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
         end else if (req_off == '0) begin
            state_d    = S_RESP;
            rsp_err_d  = 1'b0;
            rsp_data_d = rd_word;
         end else begin
            state_d = S_HI;
            lo_d    = rd_word;
            widx_d  = req_widx[IDX_W-1:0];
            off_d   = req_off;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: reset state, aligned/unaligned fetch,
// back-to-back throughput, range errors, backpressure, load/HI interaction,
// and reset in the middle of a fetch.
module tb_imem_fetch_port;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        rsp_ready = 1'b0;
   logic        ld_en = 1'b0;
   logic [7:0]  ld_idx = '0;
   logic [31:0] ld_data = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_data;

   logic        na_req_valid = 1'b0;
   logic [31:0] na_req_addr = '0;
   logic        na_rsp_ready = 1'b1;
   logic        na_req_ready, na_rsp_valid, na_rsp_err;
   logic [31:0] na_rsp_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imem_fetch_port #(.WORD_W(32), .DEPTH(256), .ADDR_W(32), .UNALIGNED(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
   );

   imem_fetch_port #(.WORD_W(32), .DEPTH(256), .ADDR_W(32), .UNALIGNED(0)) dut_na (
      .clk(clk), .rst(rst),
      .req_valid(na_req_valid), .req_ready(na_req_ready), .req_addr(na_req_addr),
      .rsp_valid(na_rsp_valid), .rsp_ready(na_rsp_ready), .rsp_data(na_rsp_data),
      .rsp_err(na_rsp_err),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called and returns at a falling edge.
   task automatic load(input logic [7:0] idx, input logic [31:0] data);
      ld_en   = 1'b1;
      ld_idx  = idx;
      ld_data = data;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Issue one fetch with rsp_ready high; latency counted in cycles after accept.
   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat);
      int lat;
      req_valid = 1'b1;
      req_addr  = addr;
      rsp_ready = 1'b1;
      #1 check({tag, " ready"}, req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " lat"}, lat, exp_lat);
      check({tag, " data"}, rsp_data, exp_data);
      check({tag, " err"}, rsp_err, exp_err);
      @(negedge clk);
      check({tag, " drained"}, rsp_valid, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst rsp_data", rsp_data, 0);
      check("rst rsp_err", rsp_err, 0);
      check("rst req_ready", req_ready, 0);
      check("rst na rsp_valid", na_rsp_valid, 0);
      rst = 1'b0;
      @(negedge clk);

      load(8'd0, 32'h1122_3344);
      load(8'd1, 32'h5566_7788);

      fetch("al0", 32'h0, 32'h1122_3344, 1'b0, 1);
      fetch("un1", 32'h1, 32'h2233_4455, 1'b0, 2);
      fetch("un3", 32'h3, 32'h4455_6677, 1'b0, 2);

      // Back-to-back aligned fetches.
      req_valid = 1'b1;
      req_addr  = 32'h0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("b2b first valid", rsp_valid, 1);
      check("b2b first data", rsp_data, 32'h1122_3344);
      check("b2b ready", req_ready, 1);
      req_addr = 32'h4;
      @(negedge clk);
      check("b2b second valid", rsp_valid, 1);
      check("b2b second data", rsp_data, 32'h5566_7788);
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b drained", rsp_valid, 0);

      // Range errors.
      fetch("oob hi", 32'h3FD, 32'h0, 1'b1, 2);
      fetch("oob widx", 32'h400, 32'h0, 1'b1, 1);

      // Unaligned disallowed instance.
      na_req_valid = 1'b1;
      na_req_addr  = 32'h2;
      @(negedge clk);
      na_req_valid = 1'b0;
      check("na un valid", na_rsp_valid, 1);
      check("na un err", na_rsp_err, 1);
      check("na un data", na_rsp_data, 0);
      @(negedge clk);
      na_req_valid = 1'b1;
      na_req_addr  = 32'h0;
      @(negedge clk);
      na_req_valid = 1'b0;
      check("na al data", na_rsp_data, 32'h1122_3344);
      check("na al err", na_rsp_err, 0);
      @(negedge clk);

      // Fetch issued right after a load sees the new word.
      load(8'd2, 32'h99AA_BBCC);
      fetch("un6 new", 32'h6, 32'h7788_99AA, 1'b0, 2);

      // Load during HI stalls the second read by one cycle.
      req_valid = 1'b1;
      req_addr  = 32'h2;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      ld_en     = 1'b1;
      ld_idx    = 8'd5;
      ld_data   = 32'hCAFE_F00D;
      #1 check("hi ld req_ready", req_ready, 0);
      check("hi ld valid1", rsp_valid, 0);
      @(negedge clk);
      ld_en = 1'b0;
      check("hi ld valid2", rsp_valid, 0);
      @(negedge clk);
      check("hi ld valid3", rsp_valid, 1);
      check("hi ld data", rsp_data, 32'h3344_5566);
      check("hi ld err", rsp_err, 0);
      @(negedge clk);
      fetch("al14", 32'h14, 32'hCAFE_F00D, 1'b0, 1);

      // Backpressure holds the response.
      req_valid = 1'b1;
      req_addr  = 32'h1;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("hold valid", rsp_valid, 1);
         check("hold data", rsp_data, 32'h2233_4455);
         check("hold req_ready", req_ready, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("hold released", rsp_valid, 0);

      // Reset while in HI discards the fetch.
      req_valid = 1'b1;
      req_addr  = 32'h1;
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      #1 check("mid rst req_ready", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      check("mid rst valid", rsp_valid, 0);
      #1 check("mid rst idle", req_ready, 1);
      @(negedge clk);
      check("mid rst no rsp", rsp_valid, 0);
      fetch("refetch0", 32'h0, 32'h1122_3344, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
